// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: bus widths, the NOP encoding, reset PC and the fetch-entry record.
// Used by fetch, the instruction memory and decode alike.
package cpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic               fault;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries with a single-cycle flush; a push is visible at the head next cycle.
// No internal backpressure: the caller only pushes when not full, or when full with a same-cycle pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [FETCH_ENTRY_W-1:0]   push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [FETCH_ENTRY_W-1:0]   head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t      mem_q [DEPTH];
  fetch_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = fetch_entry_t'(push_dat);
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Push and pop together leave the occupancy unchanged, including when full.
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the PC to imem, queues {pc, fault, instr}, hands the head to decode; redirects flush.
// Latency: 1 cycle reset/fetch to head, 2-cycle redirect bubble; fetch stalls while the queue is full and not draining.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                DEPTH      = 4,
  parameter int                IMEM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [INSTR_W-1:0]  out_instr,
  output logic                out_fault
);

  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_WORDS);

  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic                     fetch_fault;
  logic                     push, pop;
  logic                     q_full;
  logic                     unused_q_empty;
  logic                     unused_redirect_lsb;
  logic [CNT_W-1:0]         q_count;
  fetch_entry_t             push_entry;
  fetch_entry_t             head_entry;
  logic [FETCH_ENTRY_W-1:0] head_dat;

  assign fetch_fault = (fetch_pc_q >> 2) >= IMEM_LIMIT;

  always_comb begin
    push_entry.pc    = fetch_pc_q;
    push_entry.fault = fetch_fault;
    push_entry.instr = fetch_fault ? NOP_INSTR : imem_instr;
  end

  // A redirect masks the head so no wrong-path instruction is handed over in the flush cycle.
  assign out_valid = (q_count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = fetch_en && !redirect_valid && (!q_full || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .head_dat (head_dat),
    .count    (q_count),
    .full     (q_full),
    .empty    (unused_q_empty)
  );

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign head_entry = fetch_entry_t'(head_dat);
  assign imem_addr  = fetch_pc_q;
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;
  assign out_fault  = head_entry.fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 256-word instruction memory holding word i = i+1.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  logic [31:0] imem [256];

  int n_vec  = 0;
  int n_miss = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads return garbage so the NOP substitution is observable.
  always_comb begin
    if (imem_addr[31:10] == 22'd0) imem_instr = imem[imem_addr[9:2]];
    else                           imem_instr = 32'hDEAD_BEEF;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic fault);
    chk_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk_eq({tag, ".pc"},    out_pc,             pc);
    chk_eq({tag, ".instr"}, out_instr,          instr);
    chk_eq({tag, ".fault"}, {31'd0, out_fault}, {31'd0, fault});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'(i + 1);
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    tick();
    tick();

    // Reset state
    settle();
    chk_eq("rst.valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rst.pc",    out_pc,             32'h0);
    chk_eq("rst.instr", out_instr,          32'h0);
    chk_eq("rst.fault", {31'd0, out_fault}, 32'd0);
    chk_eq("rst.addr",  imem_addr,          32'h0);

    // 1: streaming after reset release
    tick();
    rst       = 1'b0;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    settle();
    chk_eq("t1.first_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      settle();
      chk_head("t1.stream", 32'(4 * k), 32'(k + 1), 1'b0);
    end

    // 2: stall decode until the queue saturates
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    settle();
    chk_eq("t2.addr_hold", imem_addr, 32'h10);
    chk_head("t2.full_head", 32'h0, 32'h1, 1'b0);

    // 2/3: release from full, push and pop every cycle
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk_head("t3.drain", 32'(4 * k), 32'(k + 1), 1'b0);
      chk_eq("t3.addr", imem_addr, 32'(32'h10 + 4 * k));
      tick();
    end

    // 4: redirect with three entries queued
    fetch_en = 1'b0;
    settle();
    chk_head("t4.pre", 32'h20, 32'h9, 1'b0);
    tick();
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    settle();
    chk_eq("t4.mask", {31'd0, out_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    chk_eq("t4.bubble", {31'd0, out_valid}, 32'd0);
    chk_eq("t4.addr",   imem_addr,          32'h40);
    tick();
    settle();
    chk_head("t4.target", 32'h40, 32'd17, 1'b0);
    tick();
    settle();
    chk_head("t4.next", 32'h44, 32'd18, 1'b0);

    // 5: last in-range word, first out-of-range word, PC wrap
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_03FC;
    tick();
    redirect_valid = 1'b0;
    tick();
    settle();
    chk_head("t5.last", 32'h3FC, 32'd256, 1'b0);
    tick();
    settle();
    chk_head("t5.oob", 32'h400, 32'h0, 1'b1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    settle();
    chk_head("t5.top", 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk_eq("t5.wrap_addr", imem_addr, 32'h0);
    tick();
    settle();
    chk_head("t5.wrapped", 32'h0, 32'h1, 1'b0);

    // 6: reset mid-stream with two entries queued
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    out_ready      = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk_eq("t6.valid", {31'd0, out_valid}, 32'd0);
    chk_eq("t6.addr",  imem_addr,          32'h0);
    tick();
    settle();
    chk_head("t6.resume", 32'h0, 32'h1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
